mul_issue_ctrl: RTL

//  Front-end sequencer for the 16x16 radix-4 Booth multiplier (start/busy/z interface).
//  - Buffers signed operand pairs from a valid/ready stream in a small FIFO.
//  - Issues one pair at a time to the multiplier: drives x/y, pulses start, tracks busy.
//  - Captures the 32-bit product and presents it on a valid/ready output stream.

---
 rtl/mul_issue_ctrl.sv | 297 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/mul_issue_ctrl.sv
// -----------------------------------------------------------------------------
// mul_issue_ctrl
//
// Front-end sequencer for a 16x16 radix-4 Booth multiplier that exposes a
// start/busy/z handshake. Signed operand pairs arrive on a valid/ready stream
// and are buffered in a small FIFO. Pairs are issued one at a time. The
// product is captured and offered on a valid/ready output stream.
//
// Optional feature (compile-time macro MUL_TIMEOUT_EN):
//   Builds a watchdog that abandons an operation when the multiplier takes
//   more than TIMEOUT cycles. The result then carries out_z = 0 and
//   out_err = 1. The operand pair is dropped and is not retried.
//   Without the macro, no counter is built, out_err is tied to 0, and the
//   sequencer waits for the multiplier indefinitely.
//
// Parameters
//   W          operand width; products are 2*W bits
//   FIFO_DEPTH operand FIFO entries (power of 2, >= 2)
//   TIMEOUT    watchdog limit in cycles (meaningful only with MUL_TIMEOUT_EN)
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset (multiplier is reset alongside)
//   in_valid   operand pair valid
//   in_ready   FIFO not full; a pair is taken when in_valid && in_ready
//   in_x       signed multiplicand
//   in_y       signed multiplier
//   mul_start  one-cycle start pulse to the multiplier
//   mul_x      registered multiplicand, stable from start until busy falls
//   mul_y      registered multiplier, same timing as mul_x
//   mul_busy   multiplier busy flag
//   mul_z      multiplier product, valid once busy falls
//   out_valid  product valid; held until accepted
//   out_ready  consumer ready
//   out_z      captured product, bit-for-bit copy of mul_z
//   out_err    timeout flag, meaningful while out_valid is high
//   fifo_cnt   current FIFO occupancy
// -----------------------------------------------------------------------------
module mul_issue_ctrl #(
  parameter int W          = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [W-1:0]                in_x,
  input  logic [W-1:0]                in_y,
  output logic                        mul_start,
  output logic [W-1:0]                mul_x,
  output logic [W-1:0]                mul_y,
  input  logic                        mul_busy,
  input  logic [2*W-1:0]              mul_z,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [2*W-1:0]              out_z,
  output logic                        out_err,
  output logic [$clog2(FIFO_DEPTH):0] fifo_cnt
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ISSUE     = 3'd1;
  localparam logic [2:0] S_WAIT_BUSY = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_DONE      = 3'd4;

  // Elaboration-time parameter sanity checks.
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("mul_issue_ctrl: FIFO_DEPTH must be a power of 2 and >= 2");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("mul_issue_ctrl: TIMEOUT must be >= 1");
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [2:0]     state_q, state_d;
  logic           start_q, start_d;
  logic [W-1:0]   mx_q, mx_d;
  logic [W-1:0]   my_q, my_d;
  logic           ov_q, ov_d;
  logic [2*W-1:0] oz_q, oz_d;

  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*W-1:0] mem_q [FIFO_DEPTH];

  logic           push;
  logic           pop;
  logic           issue;
  logic           fifo_empty;
  logic [W-1:0]   head_x;
  logic [W-1:0]   head_y;
  logic           timed_out;

  // ---------------------------------------------------------------------------
  // Operand FIFO
  // ---------------------------------------------------------------------------
  // in_ready depends only on occupancy: a pop in the same cycle does not make
  // room for a push into a full FIFO (no bypass path).
  assign in_ready   = (cnt_q != CNT_FULL);
  assign fifo_empty = (cnt_q == '0);
  assign push       = in_valid && in_ready;
  assign {head_x, head_y} = mem_q[rd_ptr_q];

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the block leaves one unassigned and no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    // Power-of-two depth lets the pointers wrap by plain overflow.
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;   // idle, or push and pop cancel out
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; an entry is only read after it has
    // been written, and reset clears the occupancy that guards those reads.
    if (push) mem_q[wr_ptr_q] <= {in_x, in_y};
  end

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
`ifdef MUL_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 2);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;

  // The counter is cleared while in ISSUE, so it is zero in the first cycle
  // of WAIT_BUSY. It then counts every cycle spent waiting. "Exceeds" means
  // strictly greater than TIMEOUT.
  assign timed_out = (wd_q > WD_W'(TIMEOUT));

  always_comb begin
    wd_d = wd_q;
    if (state_q == S_ISSUE) begin
      wd_d = '0;
    end else if ((state_q == S_WAIT_BUSY) || (state_q == S_WAIT_DONE)) begin
      wd_d = wd_q + WD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign out_err = err_q;
`else
  assign timed_out = 1'b0;
  assign out_err   = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Issue sequencer
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    start_d = 1'b0;    // start is never held past the ISSUE cycle
    mx_d    = mx_q;
    my_d    = my_q;
    ov_d    = ov_q;
    oz_d    = oz_q;
    issue   = 1'b0;
    pop     = 1'b0;
`ifdef MUL_TIMEOUT_EN
    err_d   = err_q;
`endif

    case (state_q)
      S_IDLE: begin
        issue = !fifo_empty;
      end

      S_ISSUE: begin
        state_d = S_WAIT_BUSY;
      end

      S_WAIT_BUSY: begin
        if (mul_busy) begin
          state_d = S_WAIT_DONE;
        end
`ifdef MUL_TIMEOUT_EN
        else if (timed_out) begin
          state_d = S_DONE;
          oz_d    = '0;
          ov_d    = 1'b1;
          err_d   = 1'b1;
        end
`endif
      end

      S_WAIT_DONE: begin
        // A real completion wins over a watchdog expiring in the same cycle.
        if (!mul_busy) begin
          state_d = S_DONE;
          oz_d    = mul_z;
          ov_d    = 1'b1;
`ifdef MUL_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
`ifdef MUL_TIMEOUT_EN
        else if (timed_out) begin
          state_d = S_DONE;
          oz_d    = '0;
          ov_d    = 1'b1;
          err_d   = 1'b1;
        end
`endif
      end

      S_DONE: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          state_d = S_IDLE;
`ifdef MUL_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          // If another pair is waiting, skip IDLE and issue it directly.
          // This sustains one product per 11 cycles.
          issue = !fifo_empty;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Shared issue path: pop the head, register it, and pulse start.
    if (issue) begin
      pop     = 1'b1;
      mx_d    = head_x;
      my_d    = head_y;
      start_d = 1'b1;
      state_d = S_ISSUE;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only. Every
    // register then samples pre-edge values regardless of evaluation order.
    if (rst) begin
      state_q  <= S_IDLE;
      start_q  <= 1'b0;
      mx_q     <= '0;
      my_q     <= '0;
      ov_q     <= 1'b0;
      oz_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      mx_q     <= mx_d;
      my_q     <= my_d;
      ov_q     <= ov_d;
      oz_q     <= oz_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign mul_start = start_q;
  assign mul_x     = mx_q;
  assign mul_y     = my_q;
  assign out_valid = ov_q;
  assign out_z     = oz_q;
  assign fifo_cnt  = cnt_q;

endmodule
